mux_4to1: RTL and testbench

MUX_4TO1 -- requirements
Module: mux_4to1

---
 rtl/mux_4to1.sv | 43 ++++
 tb/tb_mux_4to1.sv | 115 +++++++++++
 2 files changed

// File: rtl/mux_4to1.sv
// mux_4to1: registered 4-way data selector with valid qualifier and synchronous active-low reset
module mux_4to1 #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_sel,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_sel
);
  logic [WIDTH-1:0] data_q, data_d, pick;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  // pick the addressed input; data and select only advance on a valid sample
  always_comb begin
    pick    = i_sel[1] ? (i_sel[0] ? i_d : i_c) : (i_sel[0] ? i_b : i_a);
    data_d  = i_valid ? pick : data_q;
    sel_d   = i_valid ? i_sel : sel_q;
    valid_d = i_valid;
  end
  // output registers; reset overrides any sample arriving on the same edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q  <= RST_VAL;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end
  assign o_data  = data_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench driving a 1-bit and an 8-bit selector with directed and random traffic
module tb_mux_4to1;
  localparam logic [7:0] RST8 = 8'hA5;
  logic       clk = 1'b0;
  logic       rst_n, valid;
  logic [1:0] sel;
  logic [7:0] a8, b8, c8, d8;
  logic       a1, b1, c1, d1;
  logic [7:0] o_data8;
  logic       o_data1, o_valid8, o_valid1;
  logic [1:0] o_sel8, o_sel1;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic       v;
    logic [7:0] d8;
    logic       d1;
    logic [1:0] s;
  } exp_t;
  exp_t q[$];
  logic [7:0] m_d8;
  logic       m_d1;
  logic [1:0] m_s;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a1), .i_b(b1), .i_c(c1), .i_d(d1),
    .i_sel(sel), .i_valid(valid), .o_data(o_data1), .o_valid(o_valid1), .o_sel(o_sel1)
  );
  mux_4to1 #(.WIDTH(8), .RST_VAL(RST8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a8), .i_b(b8), .i_c(c8), .i_d(d8),
    .i_sel(sel), .i_valid(valid), .o_data(o_data8), .o_valid(o_valid8), .o_sel(o_sel8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs, let the edge sample them, then record the expected outputs
  task automatic drive(input logic rn, input logic v, input logic [1:0] s,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input bit glitch = 0);
    logic [7:0] vals [4];
    exp_t e;
    rst_n = rn; valid = v; sel = s;
    a8 = a; b8 = b; c8 = c; d8 = d;
    a1 = a[0]; b1 = b[0]; c1 = c[0]; d1 = d[0];
    if (glitch) begin
      #2 a8 = ~a; a1 = ~a[0];
      #3 a8 = a;  a1 = a[0];
    end
    @(posedge clk);
    vals = '{a, b, c, d};
    if (!rn) begin
      m_d8 = RST8; m_d1 = 1'b0; m_s = 2'd0; e.v = 1'b0;
    end else if (v) begin
      m_d8 = vals[s]; m_d1 = vals[s][0]; m_s = s; e.v = 1'b1;
    end else
      e.v = 1'b0;
    e.d8 = m_d8; e.d1 = m_d1; e.s = m_s;
    q.push_back(e);
    #1;
  endtask

  // monitor: one expected response per sampled edge, compared mid-cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("valid_w1", 32'(o_valid1), 32'(e.v));
      chk("valid_w8", 32'(o_valid8), 32'(e.v));
      chk("data_w8", 32'(o_data8), 32'(e.d8));
      chk("data_w1", 32'(o_data1), 32'(e.d1));
      chk("sel_w8", 32'(o_sel8), 32'(e.s));
      chk("sel_w1", 32'(o_sel1), 32'(e.s));
    end
  end

  initial begin
    logic [7:0] r;
    #1;
    drive(0, 1, 2'd1, 8'h12, 8'h34, 8'h56, 8'h78);
    drive(0, 0, 2'd2, 8'h00, 8'hFF, 8'h00, 8'hFF);
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 16; n++) begin
        r = 8'($urandom);
        drive(1, 1, 2'(s), {r[7:1], n[0]}, {r[6:0], n[1]}, {r[5:0], r[7], n[2]}, {r[4:0], r[7:6], n[3]});
      end
    drive(1, 1, 2'd2, 8'h00, 8'h00, 8'h01, 8'h00);
    drive(1, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1, 1, 2'd1, 8'h3C, 8'hC3, 8'h00, 8'h00);
    drive(0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(1, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(1, 1, 2'd0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(1, 1, 2'd3, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++)
      drive(1, 1, 2'(s), 8'h11, 8'h22, 8'h44, 8'h88);
    drive(1, 1, 2'd0, 8'h6B, 8'h00, 8'h00, 8'h00, 1);
    drive(1, 0, 2'd0, 8'h94, 8'h00, 8'h00, 8'h00, 1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 19) != 0, 1'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
